// File: rtl/mux8_rr_sched_pkg.sv
// Shared constants, the output-stage event type and the one-hot helper
// used by the round-robin scheduler.
package mux8_rr_sched_pkg;

    localparam int RR_N     = 8;
    localparam int RR_W     = 8;
    localparam int RR_MAX_N = 64;
    localparam int RR_IDX_W = $clog2(RR_MAX_N);

    typedef enum logic [1:0] {
        OP_IDLE  = 2'd0,
        OP_LOAD  = 2'd1,
        OP_DRAIN = 2'd2,
        OP_STALL = 2'd3
    } stage_op_e;

    // Wide one-hot; callers truncate to their own channel count.
    function automatic logic [RR_MAX_N-1:0] onehot(input logic [RR_IDX_W-1:0] idx);
        logic [RR_MAX_N-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/mux8_rr_sched_rr_pick.sv
// Combinational round-robin picker: rotate the request vector so the slot after
// the pointer sits at bit 0, priority-encode, then rotate the index back.
module mux8_rr_sched_rr_pick
    import mux8_rr_sched_pkg::*;
#(
    parameter int N  = RR_N,
    parameter int SW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [SW-1:0] ptr_i,
    output logic [SW-1:0] gnt_idx_o,
    output logic          any_o
);

    logic [N-1:0]  rot_s;
    logic [SW-1:0] base_s;
    logic [SW-1:0] enc_s;

    // N is a power of two, so SW-bit arithmetic wraps modulo N for free.
    assign base_s = ptr_i + SW'(1);

    always_comb begin
        rot_s = '0;
        for (int i = 0; i < N; i++) begin
            rot_s[i] = req_i[base_s + SW'(i)];
        end
    end

    always_comb begin
        enc_s = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot_s[i]) begin
                enc_s = SW'(i);
            end else begin
                enc_s = enc_s;
            end
        end
    end

    assign gnt_idx_o = base_s + enc_s;
    assign any_o     = |req_i;

endmodule

// File: rtl/mux8_rr_sched.sv
// Round-robin scheduler sharing an N:1 mux between N requesters, with a
// registered valid/ready output stage that refills on the same edge it drains.
module mux8_rr_sched
    import mux8_rr_sched_pkg::*;
#(
    parameter int N = RR_N,
    parameter int W = RR_W,
    localparam int SW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] din,
    output logic [N-1:0]   ack,
    output logic [SW-1:0]  sel,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   out_data
);

    logic [SW-1:0] ptr_q, ptr_d;
    logic [SW-1:0] sel_q, sel_d;
    logic [W-1:0]  data_q, data_d;
    logic          valid_q, valid_d;
    logic [N-1:0]  ack_q, ack_d;

    logic [SW-1:0] gnt_idx_s;
    logic          any_s;
    logic          load_s;
    logic [W-1:0]  mux_s;
    stage_op_e     op_s;

    mux8_rr_sched_rr_pick #(
        .N  (N),
        .SW (SW)
    ) u_pick (
        .req_i     (req),
        .ptr_i     (ptr_q),
        .gnt_idx_o (gnt_idx_s),
        .any_o     (any_s)
    );

    always_comb begin
        mux_s = '0;
        for (int k = 0; k < N; k++) begin
            if (gnt_idx_s == SW'(k)) begin
                mux_s = din[k*W +: W];
            end else begin
                mux_s = mux_s;
            end
        end
    end

    // A free or draining stage takes a new word; otherwise the grant waits.
    assign load_s = any_s & (~valid_q | out_ready);

    always_comb begin
        if (load_s) begin
            op_s = OP_LOAD;
        end else if (valid_q & out_ready) begin
            op_s = OP_DRAIN;
        end else if (valid_q) begin
            op_s = OP_STALL;
        end else begin
            op_s = OP_IDLE;
        end
    end

    always_comb begin
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        data_d  = data_q;
        valid_d = valid_q;
        ack_d   = '0;
        case (op_s)
            OP_LOAD: begin
                data_d  = mux_s;
                valid_d = 1'b1;
                sel_d   = gnt_idx_s;
                ptr_d   = gnt_idx_s;
                ack_d   = N'(onehot(RR_IDX_W'(gnt_idx_s)));
            end
            OP_DRAIN: begin
                valid_d = 1'b0;
            end
            OP_STALL: begin
                valid_d = 1'b1;
            end
            OP_IDLE: begin
                valid_d = 1'b0;
            end
            default: begin
                valid_d = 1'b0;
            end
        endcase
    end

    // Pointer starts at N-1 so channel 0 wins the first arbitration.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q   <= SW'(N - 1);
            sel_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ack_q   <= '0;
        end else begin
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ack_q   <= ack_d;
        end
    end

    assign ack       = ack_q;
    assign sel       = sel_q;
    assign out_valid = valid_q;
    assign out_data  = data_q;

endmodule

// File: tb/tb_mux8_rr_sched.sv
// Bench for mux8_rr_sched: directed scenarios plus random traffic, checked by a
// grant scoreboard and a downstream word scoreboard fed from a reference model.
module tb_mux8_rr_sched;

    localparam int N  = 8;
    localparam int W  = 8;
    localparam int SW = 3;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*W-1:0] din;
    logic [N-1:0]   ack;
    logic [SW-1:0]  sel;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_data;

    always #5 clk = ~clk;

    mux8_rr_sched #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .din       (din),
        .ack       (ack),
        .sel       (sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    typedef struct {
        int         ch;
        logic [W-1:0] data;
    } grant_t;

    grant_t       gnt_q[$];
    logic [W-1:0] acc_q[$];
    logic [W-1:0] din_w[N];

    int n_checks = 0;
    int n_fail   = 0;
    int mdl_ptr;
    bit mdl_valid;
    int mdl_last_g;
    bit mon_en = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs and predict the scheduler's decision from the rules.
    task automatic step(input bit r, input logic [N-1:0] rq, input bit rdy);
        @(negedge clk);
        rst       = r;
        req       = rq;
        out_ready = rdy;
        for (int k = 0; k < N; k++) din[k*W +: W] = din_w[k];
        mdl_last_g = -1;
        if (r) begin
            mdl_ptr   = N - 1;
            mdl_valid = 1'b0;
            gnt_q.delete();
            acc_q.delete();
        end else if (rq != '0 && (!mdl_valid || rdy)) begin
            for (int s = 1; s <= N; s++) begin
                int c = (mdl_ptr + s) % N;
                if (rq[c] && mdl_last_g < 0) mdl_last_g = c;
            end
            gnt_q.push_back('{ch: mdl_last_g, data: din_w[mdl_last_g]});
            mdl_ptr   = mdl_last_g;
            mdl_valid = 1'b1;
        end else if (mdl_valid && rdy) begin
            mdl_valid = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    // Grant monitor: every ack must match the next predicted grant.
    initial forever begin
        grant_t g;
        @(posedge clk);
        #1;
        if (mon_en) begin
            if (ack != '0) begin
                if (gnt_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_ack: got ack=%0h expected no grant", ack);
                end else begin
                    g = gnt_q.pop_front();
                    chk("ack_onehot", longint'(ack), longint'(1) << g.ch);
                    chk("sel", longint'(sel), longint'(g.ch));
                    chk("grant_data", longint'(out_data), longint'(g.data));
                    chk("valid_on_grant", longint'(out_valid), 1);
                    acc_q.push_back(g.data);
                end
            end else if (gnt_q.size() != 0) begin
                g = gnt_q.pop_front();
                n_checks++;
                n_fail++;
                $display("FAIL missing_ack: got ack=0 expected grant ch%0d", g.ch);
            end
        end
    end

    // Downstream monitor: each captured word is presented until accepted, in order.
    initial forever begin
        @(negedge clk);
        #1;
        if (mon_en && !rst) begin
            if (out_valid) begin
                if (acc_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL valid_without_word: got out_valid=1 expected 0");
                end else begin
                    chk("held_data", longint'(out_data), longint'(acc_q[0]));
                    if (out_ready) void'(acc_q.pop_front());
                end
            end else begin
                chk("word_lost", longint'(acc_q.size()), 0);
            end
        end
    end

    initial begin
        logic [N-1:0] rq;
        bit           r;
        for (int k = 0; k < N; k++) din_w[k] = 8'h10 + 8'(k);
        rst = 1'b1; req = '0; din = '0; out_ready = 1'b0;

        // Reset with everyone requesting, then the first grant goes to ch0.
        step(1'b1, 8'hFF, 1'b1);
        mon_en = 1'b1;
        chk("rst_valid", longint'(out_valid), 0);
        chk("rst_ack", longint'(ack), 0);
        chk("rst_sel", longint'(sel), 0);
        chk("rst_data", longint'(out_data), 0);
        step(1'b1, 8'hFF, 1'b1);
        chk("rst2_valid", longint'(out_valid), 0);
        step(1'b0, 8'hFF, 1'b1);
        chk("first_ack", longint'(ack), 8'h01);
        chk("first_data", longint'(out_data), 8'h10);

        // All requesting: grants walk 1..7 then wrap to 0.
        for (int i = 1; i <= N; i++) begin
            step(1'b0, 8'hFF, 1'b1);
            chk("walk_data", longint'(out_data), longint'(8'h10 + (i % N)));
            chk("walk_ack", longint'(ack), longint'(1) << (i % N));
        end

        // Pointer at 2, requests on 7 and 2: grant 7 then wrap to 2.
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h04, 1'b1);
        chk("ptr2_ack", longint'(ack), 8'h04);
        step(1'b0, 8'h84, 1'b1);
        chk("wrap_ack7", longint'(ack), 8'h80);
        step(1'b0, 8'h84, 1'b1);
        chk("wrap_ack2", longint'(ack), 8'h04);

        // Backpressure on a ch3 word.
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h08, 1'b0);
        chk("bp_grant", longint'(ack), 8'h08);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 8'h08, 1'b0);
            chk("bp_ack", longint'(ack), 0);
            chk("bp_sel", longint'(sel), 3);
            chk("bp_valid", longint'(out_valid), 1);
            chk("bp_data", longint'(out_data), longint'(din_w[3]));
        end
        step(1'b0, 8'h00, 1'b1);

        // Single requester ch5 streams at full rate.
        step(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 8'h20, 1'b1);
            chk("single_ack", longint'(ack), 8'h20);
            chk("single_valid", longint'(out_valid), 1);
        end

        // Reset mid-stream discards the word and restarts arbitration at ch0.
        step(1'b0, 8'hFF, 1'b1);
        step(1'b1, 8'hFF, 1'b1);
        chk("midrst_valid", longint'(out_valid), 0);
        chk("midrst_ack", longint'(ack), 0);
        step(1'b0, 8'hFF, 1'b1);
        chk("midrst_first", longint'(ack), 8'h01);

        // Random traffic obeying the requester rules.
        rq = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int k = 0; k < N; k++) begin
                if (k == mdl_last_g) begin
                    if ($urandom % 2 == 0) rq[k] = 1'b0;
                    else din_w[k] = 8'($urandom);
                end else if (!rq[k]) begin
                    if ($urandom % 10 < 3) begin
                        rq[k]    = 1'b1;
                        din_w[k] = 8'($urandom);
                    end
                end else if ($urandom % 20 == 0) begin
                    rq[k] = 1'b0;
                end
            end
            r = ($urandom % 150 == 0);
            step(r, rq, ($urandom % 4) != 0);
        end

        for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1);
        chk("grants_drained", longint'(gnt_q.size()), 0);
        chk("words_drained", longint'(acc_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
